// File: rtl/tt_um_uwasic_onboarding_herman_gahra_pkg.sv
// tt_um_uwasic_onboarding_herman_gahra_pkg: register map, SPI frame geometry and PWM defaults
package tt_um_uwasic_onboarding_herman_gahra_pkg;
  localparam int TXN_W = 16;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int PWM_PRESCALE_DEF = 13;
  localparam logic [ADDR_W-1:0] REG_EN_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] REG_EN_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] REG_EN_PWM_LO = 7'h02;
  localparam logic [ADDR_W-1:0] REG_EN_PWM_HI = 7'h03;
  localparam logic [ADDR_W-1:0] REG_DUTY = 7'h04;
endpackage

// File: rtl/tt_um_uwasic_onboarding_herman_gahra_spi.sv
// spi_peripheral: mode-0 SPI write-only receiver holding the five control registers
module spi_peripheral
  import tt_um_uwasic_onboarding_herman_gahra_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              copi,
  input  logic              ncs,
  output logic [DATA_W-1:0] en_out_lo,
  output logic [DATA_W-1:0] en_out_hi,
  output logic [DATA_W-1:0] en_pwm_lo,
  output logic [DATA_W-1:0] en_pwm_hi,
  output logic [DATA_W-1:0] duty
);
  logic [2:0] sclk_s, ncs_s;
  logic [1:0] copi_s;
  logic active;
  logic [4:0] cnt;
  logic [TXN_W-1:0] sh;
  logic sclk_rise, ncs_fall, ncs_rise, valid;
  assign sclk_rise = sclk_s[1] & ~sclk_s[2];
  assign ncs_fall = ~ncs_s[1] & ncs_s[2];
  assign ncs_rise = ncs_s[1] & ~ncs_s[2];
  assign valid = active && cnt == 5'(TXN_W) && sh[TXN_W-1] && sh[TXN_W-2 -: ADDR_W] <= REG_DUTY;
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sclk_s <= '0;
      ncs_s <= '0;
      copi_s <= '0;
    end else begin
      sclk_s <= {sclk_s[1:0], sclk};
      ncs_s <= {ncs_s[1:0], ncs};
      copi_s <= {copi_s[0], copi};
    end
  end
  // active only after a genuine nCS fall, so a reset mid-frame can never commit
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      active <= 1'b0;
      cnt <= '0;
      sh <= '0;
      en_out_lo <= '0;
      en_out_hi <= '0;
      en_pwm_lo <= '0;
      en_pwm_hi <= '0;
      duty <= '0;
    end else begin
      if (ncs_fall) begin
        active <= 1'b1;
        cnt <= '0;
        sh <= '0;
      end else if (ncs_rise) begin
        active <= 1'b0;
      end else if (active && sclk_rise && !ncs_s[1]) begin
        sh <= {sh[TXN_W-2:0], copi_s[1]};
        cnt <= cnt + 5'(cnt != 5'd17);
      end
      if (ncs_rise && valid) begin
        case (sh[TXN_W-2 -: ADDR_W])
          REG_EN_OUT_LO: en_out_lo <= sh[DATA_W-1:0];
          REG_EN_OUT_HI: en_out_hi <= sh[DATA_W-1:0];
          REG_EN_PWM_LO: en_pwm_lo <= sh[DATA_W-1:0];
          REG_EN_PWM_HI: en_pwm_hi <= sh[DATA_W-1:0];
          default:       duty <= sh[DATA_W-1:0];
        endcase
      end
    end
  end
endmodule

// File: rtl/tt_um_uwasic_onboarding_herman_gahra.sv
// tt_um_uwasic_onboarding_herman_gahra: SPI-controlled 16-channel output driver
// PWM_MODE_EN enables the PWM generator; without it each channel is just en_out[i].
module tt_um_uwasic_onboarding_herman_gahra
  import tt_um_uwasic_onboarding_herman_gahra_pkg::*;
#(
  parameter int PWM_PRESCALE = PWM_PRESCALE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic [DATA_W-1:0] en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, duty;
  logic [15:0] next_out, out_q;
  logic unused;
  spi_peripheral u_spi (
    .clk(clk),
    .rst_n(rst_n),
    .sclk(ui_in[0]),
    .copi(ui_in[1]),
    .ncs(ui_in[2]),
    .en_out_lo(en_out_lo),
    .en_out_hi(en_out_hi),
    .en_pwm_lo(en_pwm_lo),
    .en_pwm_hi(en_pwm_hi),
    .duty(duty)
  );
`ifdef PWM_MODE_EN
  localparam int PW = $clog2(PWM_PRESCALE + 1);
  logic [PW-1:0] pre;
  logic [7:0] cnt;
  logic step, pwm;
  assign step = pre == PW'(PWM_PRESCALE - 1);
  assign pwm = duty == 8'hFF || cnt < duty;
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pre <= '0;
      cnt <= '0;
    end else begin
      pre <= step ? '0 : pre + PW'(1);
      cnt <= cnt + 8'(step);
    end
  end
  assign next_out = {en_out_hi, en_out_lo} & (~{en_pwm_hi, en_pwm_lo} | {16{pwm}});
  assign unused = &{ena, uio_in, ui_in[7:3], 1'b0};
`else
  assign next_out = {en_out_hi, en_out_lo};
  assign unused = &{ena, uio_in, ui_in[7:3], en_pwm_lo, en_pwm_hi, duty, 1'b0};
`endif
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) out_q <= '0;
    else out_q <= next_out;
  end
  assign {uio_out, uo_out} = out_q;
  assign uio_oe = 8'hFF;
endmodule

// File: tb/tb_tt_um_uwasic_onboarding_herman_gahra.sv
// tb_tt_um_uwasic_onboarding_herman_gahra: randomized SPI register writes checked against a register-map model
module tb_tt_um_uwasic_onboarding_herman_gahra;
  localparam int PERIOD = 256 * 13;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ena = 1'b1;
  logic [7:0] ui_in = 8'h04;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;
  int checks = 0;
  int errors = 0;
  logic [7:0] m_reg [5];

  tt_um_uwasic_onboarding_herman_gahra dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #50 clk = ~clk;

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      ui_in[1] = bits[i];
      clks(4);
      ui_in[0] = 1'b1;
      clks(4);
      ui_in[0] = 1'b0;
    end
  endtask

  // frame of n bits, MSB first; the model commits only full 16-bit writes to 0..4
  task automatic spi_xfer(input logic [31:0] bits, input int n);
    ui_in[2] = 1'b0;
    clks(6);
    send_bits(bits, n);
    clks(4);
    ui_in[2] = 1'b1;
    clks(10);
    if (n == 16 && bits[15] && bits[14:8] <= 7'd4) m_reg[bits[14:8]] = bits[7:0];
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    spi_xfer({16'h0, 1'b1, a, d}, 16);
  endtask

  // channels driven by a mid-range duty toggle, so they are masked from static checks
  task automatic check_out(input string tag);
    logic [15:0] en, pw, exp, mask;
    logic pc;
    en = {m_reg[1], m_reg[0]};
`ifdef PWM_MODE_EN
    pw = {m_reg[3], m_reg[2]};
`else
    pw = 16'h0;
`endif
    pc = m_reg[4] == 8'hFF;
    exp = en & (~pw | {16{pc}});
    mask = (m_reg[4] != 8'h00 && m_reg[4] != 8'hFF) ? (en & pw) : 16'h0;
    chk(tag, {16'h0, {uio_out, uo_out} & ~mask}, {16'h0, exp & ~mask});
  endtask

  task automatic count_ones(input int n, output int ones);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      clks(1);
      ones += int'(uo_out[0]);
    end
  endtask

  initial begin
    logic [15:0] w;
    logic [31:0] bits;
    int n, r, ones;
    model_reset();
    clks(5);
    chk("reset_uo", {24'h0, uo_out}, 32'h00);
    chk("reset_uio", {24'h0, uio_out}, 32'h00);
    chk("reset_oe", {24'h0, uio_oe}, 32'hFF);
    rst_n = 1'b0;
    clks(4);

    wr(7'h00, 8'hF0);
    wr(7'h01, 8'hCC);
    chk("write_uo", {24'h0, uo_out}, 32'hF0);
    chk("write_uio", {24'h0, uio_out}, 32'hCC);

    spi_xfer(32'h30FF, 16);
    check_out("reject_read");
    spi_xfer(32'hB0FF, 16);
    check_out("reject_addr30");
    spi_xfer(32'h80FF >> 1, 15);
    check_out("reject_15bit");
    chk("reject_uo_kept", {24'h0, uo_out}, 32'hF0);

    for (int k = 0; k < 24; k++) begin
      w = {1'($urandom_range(0, 4) != 0), 7'($urandom_range(0, 6)), 8'($urandom)};
      r = $urandom_range(0, 9);
      n = (r == 0) ? 15 : (r == 1) ? 17 : 16;
      bits = (n == 17) ? {15'h0, w, 1'b1} : (n == 15) ? {17'h0, w[15:1]} : {16'h0, w};
      spi_xfer(bits, n);
      check_out($sformatf("rand_%0d", k));
    end

    wr(7'h00, 8'h01);
    wr(7'h01, 8'h00);
    wr(7'h02, 8'h01);
    wr(7'h03, 8'h00);
    wr(7'h04, 8'h80);
`ifdef PWM_MODE_EN
    begin
      int t, hi;
      t = 0;
      while (!(uo_out[0] == 1'b0) && t < 2 * PERIOD) begin clks(1); t++; end
      while (uo_out[0] == 1'b0 && t < 2 * PERIOD) begin clks(1); t++; end
      chk("pwm_rise_seen", {31'h0, t < 2 * PERIOD}, 32'h1);
      t = 0;
      hi = 0;
      while (uo_out[0] == 1'b1 && t < 2 * PERIOD) begin clks(1); t++; hi++; end
      while (uo_out[0] == 1'b0 && t < 2 * PERIOD) begin clks(1); t++; end
      chk("pwm_period", t, PERIOD);
      chk("pwm_high_50pct", {31'h0, hi >= PERIOD / 2 - PERIOD / 100 && hi <= PERIOD / 2 + PERIOD / 100}, 32'h1);
    end
    wr(7'h04, 8'h00);
    count_ones(2 * PERIOD, ones);
    chk("duty00_ones", ones, 0);
    wr(7'h04, 8'hFF);
    count_ones(2 * PERIOD, ones);
    chk("dutyFF_ones", ones, 2 * PERIOD);
`else
    count_ones(2 * PERIOD, ones);
    chk("nopwm_ch0_high", ones, 2 * PERIOD);
    wr(7'h04, 8'h00);
    count_ones(PERIOD, ones);
    chk("nopwm_duty_ignored", ones, PERIOD);
`endif
    check_out("after_pwm");

    ui_in[2] = 1'b0;
    clks(6);
    send_bits(32'h80, 8);
    rst_n = 1'b1;
    clks(3);
    model_reset();
    chk("midrst_uo", {24'h0, uo_out}, 32'h00);
    rst_n = 1'b0;
    send_bits(32'hFF, 8);
    clks(4);
    ui_in[2] = 1'b1;
    clks(10);
    chk("midrst_no_commit", {16'h0, uio_out, uo_out}, 32'h0000);
    wr(7'h00, 8'hFF);
    chk("midrst_next_ok", {24'h0, uo_out}, 32'hFF);
    check_out("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tt_um_uwasic_onboarding_herman_gahra.md
TT_UM_UWASIC_ONBOARDING_HERMAN_GAHRA -- requirements
Module: tt_um_uwasic_onboarding_herman_gahra

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Parameter PWM_PRESCALE, default 13, SHALL set the clock cycles per PWM counter step, giving about 3 kHz PWM from a 10 MHz clock.
REQ-003 clk  input  1  SHALL be the system clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous reset, active-high (1 = in reset).
REQ-005 ena  input  1  SHALL be the design-select input and SHALL be ignored functionally.
REQ-006 ui_in  input  8  SHALL carry [0] = SCLK, [1] = COPI and [2] = nCS (active-low); bits [7:3] are unused.
REQ-007 uio_in  input  8  SHALL be unused.
REQ-008 uo_out  output  8  SHALL drive output channels 7..0.
REQ-009 uio_out  output  8  SHALL drive output channels 15..8.
REQ-010 uio_oe  output  8  SHALL be constant 8'hFF.

Function
REQ-011 SCLK, COPI and nCS SHALL each pass through a 2-flop synchronizer into clk; edges are detected on the synchronized signals.
REQ-012 SPI SHALL be mode 0: COPI is sampled on SCLK rising edges while nCS is low, MSB first.
REQ-013 A transaction SHALL be 16 bits: [15] = 1 for write (0 = read), [14:8] = address, [7:0] = data.
REQ-014 On the nCS rising edge, the block SHALL commit a transaction only if it is exactly 16 bits, a write, and addressed 0x00-0x04; the register updates 1 clk after the synchronized nCS rise.
REQ-015 Reads, wrong bit counts, and addresses 0x05-0x7F SHALL be discarded with no register change.
REQ-016 The bit counter and shift register SHALL clear on each nCS falling edge.
REQ-017 The register map SHALL be: 0x00 en_out[7:0], 0x01 en_out[15:8], 0x02 en_pwm[7:0], 0x03 en_pwm[15:8], 0x04 duty[7:0].
REQ-018 The PWM counter SHALL be 8 bits, advance once every PWM_PRESCALE clocks, and wrap from 255 to 0.
REQ-019 The PWM signal SHALL be high when counter < duty, except duty = 0xFF, which SHALL be constantly high; duty = 0x00 SHALL be constantly low.
REQ-020 Each output channel i SHALL be: 0 if en_out[i] = 0; else 1 if en_pwm[i] = 0; else the PWM signal.
REQ-021 Outputs SHALL be registered, with 1 clk latency from a register or counter change.
REQ-022 A duty write mid-period SHALL take effect on the next counter compare, without waiting for wrap-around.

Reset
REQ-023 While rst_n = 1, all registers, the PWM counter, the prescaler and the SPI state SHALL be 0 or idle, and uo_out and uio_out SHALL be 8'h00.
REQ-024 A reset asserted mid-transaction SHALL abort it, and no register SHALL change.
REQ-025 After reset deassertion, the first valid transaction SHALL require a fresh nCS falling edge.

Configuration
REQ-026 With macro PWM_MODE_EN defined, the PWM counter, duty register and en_pwm registers SHALL be implemented per REQ-018..REQ-020.
REQ-027 Without PWM_MODE_EN, addresses 0x02-0x04 SHALL be accepted but have no effect, and each output channel SHALL equal en_out[i].

Structure
REQ-028 A shared package SHALL hold the register addresses (0x00-0x04), the transaction width 16, the address width 7, the data width 8, and the PWM_PRESCALE default.
REQ-029 The SPI receiver SHALL be the sub-module spi_peripheral, outputting the five registers.
REQ-030 The PWM logic and output mux SHALL be in the top level.

Verification
REQ-031 Reset: assert rst_n = 1 for 5 clks -> uo_out = 0x00, uio_out = 0x00, uio_oe = 0xFF.
REQ-032 SPI writes: write 0x00 <- 0xF0, then 0x01 <- 0xCC -> uo_out = 0xF0, uio_out = 0xCC.
REQ-033 Rejected transactions -> no change: a read of 0x30; a write to address 0x30; a 15-bit write aborted by nCS rising early.
REQ-034 PWM at 50%: en_out[0] = 1, en_pwm[0] = 1, duty = 0x80 -> uo_out[0] has a ~3 kHz period (3328 clks) and 50% +/-1% high time.
REQ-035 PWM duty extremes: duty = 0x00 -> uo_out[0] constantly 0; duty = 0xFF -> constantly 1, each held over 2 periods.
REQ-036 Mid-transaction reset: assert reset after 8 bits of a write to 0x00 <- 0xFF -> en_out stays 0x00, and the next full write succeeds.
